// File: rtl/mem_responder.sv
// Line-granular main-memory responder: one outstanding request, fixed access latency,
// registered valid/ready response channel carrying read lines or write acknowledgements.
module mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned DEPTH_LINES = 1024,
  parameter int unsigned LATENCY     = 5
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LINE_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_we_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [LINE_W-1:0] rsp_rdata_o
);

  localparam int unsigned OFF   = $clog2(LINE_W / 8);
  localparam int unsigned IDX   = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LineMask = {{(ADDR_W - OFF){1'b1}}, {OFF{1'b0}}};

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_we_q, rsp_we_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic [LINE_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [LINE_W-1:0]   mem [DEPTH_LINES];
  logic [IDX-1:0]      idx;
  logic                commit;

  // Upper address bits beyond the index alias onto the same line.
  assign idx    = addr_q[OFF+IDX-1:OFF];
  assign commit = (state_q == StWait) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i & LineMask;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_addr_d  = addr_q;
          rsp_rdata_d = we_q ? '0 : mem[idx];
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered ready: low during reset and on the cycle of the response handshake.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage is deliberately not reset; a write lands only on the final WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (commit && we_q) begin
      mem[idx] <= wdata_q;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=5 instance for most scenarios and a
// LATENCY=1 instance for back-to-back throughput; both share the request inputs.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rsn_a, rsn_b, req_valid, req_we, rsp_ready;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;

  logic         ready_a, valid_a, we_a, ready_b, valid_b, we_b;
  logic [31:0]  addr_a, addr_b;
  logic [127:0] rdata_a, rdata_b;

  mem_responder #(.ADDR_W(32), .LINE_W(128), .DEPTH_LINES(1024), .LATENCY(5)) dut_a (
    .clk_i(clk), .rsn_i(rsn_a), .req_valid_i(req_valid), .req_ready_o(ready_a),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(valid_a), .rsp_ready_i(rsp_ready), .rsp_we_o(we_a),
    .rsp_addr_o(addr_a), .rsp_rdata_o(rdata_a)
  );

  mem_responder #(.ADDR_W(32), .LINE_W(128), .DEPTH_LINES(1024), .LATENCY(1)) dut_b (
    .clk_i(clk), .rsn_i(rsn_b), .req_valid_i(req_valid), .req_ready_o(ready_b),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(valid_b), .rsp_ready_i(rsp_ready), .rsp_we_o(we_b),
    .rsp_addr_o(addr_b), .rsp_rdata_o(rdata_b)
  );

  logic sel = 1'b0;
  wire         cur_ready = sel ? ready_b : ready_a;
  wire         cur_valid = sel ? valid_b : valid_a;
  wire         cur_we    = sel ? we_b    : we_a;
  wire [31:0]  cur_addr  = sel ? addr_b  : addr_a;
  wire [127:0] cur_rdata = sel ? rdata_b : rdata_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model[int];

  localparam logic [127:0] DatD  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DatAA = {16{8'hAA}};
  localparam logic [127:0] Dat11 = {16{8'h11}};
  localparam logic [127:0] Dat55 = {16{8'h55}};
  localparam logic [127:0] DatP  = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

  function automatic int lidx(input logic [31:0] a);
    return int'(a[13:4]);
  endfunction

  // Drives a request until accepted; optionally records the reference outcome.
  task automatic send(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                      input bit track, output int acc);
    bit ok = 1'b0;
    acc = 0;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cur_ready === 1'b1) begin
        @(posedge clk); #1; acc = cyc; ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept addr=%h got=no_acceptance want=acceptance_within_40", addr);
    end else if (track) begin
      if (we) model[lidx(addr)] = wd;
      sb.push_back('{we, addr & 32'hFFFF_FFF0, we ? 128'h0 : model[lidx(addr)]});
    end
  endtask

  task automatic wait_rsp(output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cur_valid === 1'b1) begin
        c = cyc; ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rsp_wait got=no_rsp_valid want=rsp_valid_within_40");
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rsn_a = 1'b0; rsn_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", ready_a); end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", valid_a); end
    checks++; if (we_a !== 1'b0) begin failures++; $display("FAIL rst_we got=%b want=0", we_a); end
    checks++; if (addr_a !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", addr_a); end
    checks++; if (rdata_a !== 128'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0", rdata_a); end
    rsn_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b want=1", ready_a); end
  endtask

  task automatic test_write_read();
    int acc, r;
    exp_t e;
    send(1'b1, 32'h40, DatD, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    checks++; if (r - acc != 5) begin failures++; $display("FAIL wr_latency got=%0d want=5", r - acc); end
    checks++; if (cur_we !== e.we) begin failures++; $display("FAIL wr_we got=%b want=%b", cur_we, e.we); end
    checks++; if (cur_addr !== e.addr) begin failures++; $display("FAIL wr_addr got=%h want=%h", cur_addr, e.addr); end
    checks++; if (cur_rdata !== e.data) begin failures++; $display("FAIL wr_rdata got=%h want=%h", cur_rdata, e.data); end
    @(posedge clk); #1;
    checks++; if (cur_valid !== 1'b0) begin failures++; $display("FAIL wr_drop got=%b want=0", cur_valid); end
    send(1'b0, 32'h4C, 128'h0, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    checks++; if (r - acc != 5) begin failures++; $display("FAIL rd_latency got=%0d want=5", r - acc); end
    checks++; if (cur_we !== e.we) begin failures++; $display("FAIL rd_we got=%b want=%b", cur_we, e.we); end
    checks++; if (cur_addr !== e.addr) begin failures++; $display("FAIL rd_addr got=%h want=%h", cur_addr, e.addr); end
    checks++; if (cur_rdata !== e.data) begin failures++; $display("FAIL rd_rdata got=%h want=%h", cur_rdata, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int acc, r;
    exp_t e;
    rsp_ready = 1'b0;
    send(1'b0, 32'h40, 128'h0, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (cur_valid !== 1'b1 || cur_rdata !== e.data || cur_addr !== e.addr || cur_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b a=%h d=%h rdy=%b want v=1 a=%h d=%h rdy=0",
                 k, cur_valid, cur_addr, cur_rdata, cur_ready, e.addr, e.data);
      end
      @(posedge clk); #1;
    end
    checks++; if (cur_valid !== 1'b1) begin failures++; $display("FAIL bp_hold8 got=%b want=1", cur_valid); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (cur_valid !== 1'b0) begin failures++; $display("FAIL bp_drop got=%b want=0", cur_valid); end
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL bp_ready got=%b want=1", cur_ready); end
  endtask

  task automatic test_alias();
    int acc, r;
    exp_t e;
    send(1'b1, 32'h0000_0010, DatAA, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    checks++; if (cur_we !== 1'b1 || cur_rdata !== e.data) begin failures++; $display("FAIL al_wack got we=%b d=%h want we=1 d=%h", cur_we, cur_rdata, e.data); end
    @(posedge clk); #1;
    send(1'b0, 32'h0000_4010, 128'h0, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    checks++; if (cur_rdata !== e.data) begin failures++; $display("FAIL al_rdata got=%h want=%h", cur_rdata, e.data); end
    checks++; if (cur_addr !== e.addr) begin failures++; $display("FAIL al_addr got=%h want=%h", cur_addr, e.addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy();
    int acc, r1, r2;
    exp_t e;
    send(1'b1, 32'h80, DatP, 1'b1, acc);
    wait_rsp(r1); e = sb.pop_front();
    @(posedge clk); #1;
    send(1'b0, 32'h40, 128'h0, 1'b1, acc);
    // Hold a second request through the whole WAIT/RESP of the first.
    req_we = 1'b0; req_addr = 32'h80; req_valid = 1'b1;
    sb.push_back('{1'b0, 32'h80, model[lidx(32'h80)]});
    wait_rsp(r1); e = sb.pop_front();
    checks++; if (cur_rdata !== e.data) begin failures++; $display("FAIL busy_first got=%h want=%h", cur_rdata, e.data); end
    checks++; if (cur_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b want=0", cur_ready); end
    @(posedge clk); #1;
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL busy_idle got=%b want=1", cur_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(r2); e = sb.pop_front();
    checks++; if (r2 - r1 != 7) begin failures++; $display("FAIL busy_gap got=%0d want=7", r2 - r1); end
    checks++; if (cur_rdata !== e.data || cur_addr !== e.addr) begin failures++; $display("FAIL busy_second got a=%h d=%h want a=%h d=%h", cur_addr, cur_rdata, e.addr, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int acc, r;
    exp_t e;
    send(1'b1, 32'h100, Dat11, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    @(posedge clk); #1;
    send(1'b1, 32'h100, Dat55, 1'b0, acc);
    repeat (2) @(posedge clk);
    #3;
    rsn_a = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || we_a !== 1'b0 || addr_a !== 32'h0 || rdata_a !== 128'h0 || ready_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_clear got v=%b we=%b a=%h d=%h rdy=%b want all 0",
               valid_a, we_a, addr_a, rdata_a, ready_a);
    end
    @(posedge clk); #1;
    rsn_a = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'h100, 128'h0, 1'b1, acc);
    wait_rsp(r); e = sb.pop_front();
    checks++; if (cur_rdata !== e.data) begin failures++; $display("FAIL mid_rst_keep got=%h want=%h", cur_rdata, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc, prev, r;
    exp_t e;
    logic        we_t   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] addr_t [4] = '{32'h200, 32'h210, 32'h208, 32'h21C};
    logic [127:0] dat_t [4] = '{DatAA, Dat55, 128'h0, 128'h0};
    rsn_a = 1'b0; sel = 1'b1; rsn_b = 1'b1; rsp_ready = 1'b1;
    model.delete();
    @(posedge clk); #1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      send(we_t[k], addr_t[k], dat_t[k], 1'b1, acc);
      wait_rsp(r); e = sb.pop_front();
      checks++; if (r - acc != 1) begin failures++; $display("FAIL b2b_latency k=%0d got=%0d want=1", k, r - acc); end
      if (k > 0) begin
        checks++; if (acc - prev != 3) begin failures++; $display("FAIL b2b_period k=%0d got=%0d want=3", k, acc - prev); end
      end
      checks++;
      if (cur_we !== e.we || cur_addr !== e.addr || cur_rdata !== e.data) begin
        failures++;
        $display("FAIL b2b_rsp k=%0d got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 k, cur_we, cur_addr, cur_rdata, e.we, e.addr, e.data);
      end
      prev = acc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_alias();
    test_busy();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
